// File: rtl/stream_dispatch_pkg.sv
// Shared types and constants for the 1-to-4 stream dispatcher.
package stream_dispatch_pkg;

  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    Empty = 1'b0,
    Full  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first enabled index at or after ptr, wrapping mod 4.
module rr_pick4
  import stream_dispatch_pkg::*;
(
  input  logic [NUM_OUT-1:0] mask,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   grant,
  output logic               any
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && mask[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/stream_dispatch_1x4.sv
// Registered 1-to-4 dispatcher: one holding slot, round-robin sink choice over en_mask.
module stream_dispatch_1x4
  import stream_dispatch_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_OUT-1:0] en_mask,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic [CNT_W-1:0]   sent_cnt
);

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [SEL_W-1:0]   grant;
  logic               any;
  logic               drain;
  logic               accept;

  rr_pick4 u_pick (
    .mask  (en_mask),
    .ptr   (ptr_q),
    .grant (grant),
    .any   (any)
  );

  assign drain    = (state_q == Full) && out_ready[sel_q];
  // Held low during reset so the source never sees a phantom handshake.
  assign in_ready = rst_n && any && ((state_q == Empty) || drain);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Empty;
      sel_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        data_q  <= in_data;
        sel_q   <= grant;
        ptr_q   <= grant + SEL_W'(1);
        state_q <= Full;
      end else if (drain) begin
        state_q <= Empty;
      end
      if (drain) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = (state_q == Full) ? (NUM_OUT'(1) << sel_q) : '0;
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign busy      = (state_q == Full);
  assign sent_cnt  = cnt_q;

endmodule

// File: tb/tb_stream_dispatch_1x4.sv
// Self-checking bench: per-cycle reference model plus directed scenarios and random traffic.
module tb_stream_dispatch_1x4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en_mask = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic       busy;
  logic [7:0] sent_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stream_dispatch_1x4 #(
    .DATA_W (8),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_mask   (en_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy),
    .sent_cnt  (sent_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one held beat (or none), a rotating start index, a delivery count.
  bit         m_full;
  int         m_sink;
  int         m_ptr;
  logic [7:0] m_data;
  int         m_cnt;
  logic       exp_rdy;
  bit         m_drain;
  int         g;

  // Deliveries observed on the DUT ports, plus sinks that must stay silent.
  int         log_sink[$];
  logic [7:0] log_data[$];
  logic [3:0] forbid = '0;
  bit         saw_bad = 1'b0;

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Inputs only change just after posedge, so negedge sees the values the next edge will use.
  always begin
    @(negedge clk);
    if (!rst_n) begin
      m_full = 1'b0;
      m_sink = 0;
      m_ptr  = 0;
      m_data = '0;
      m_cnt  = 0;
    end
    exp_rdy = rst_n && (en_mask != 0) && (!m_full || out_ready[m_sink]);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), m_full ? (32'd1 << m_sink) : 32'd0);
    check("out_data", 32'(out_data), 32'(m_data));
    check("sel", 32'(sel), 32'(m_sink));
    check("busy", 32'(busy), 32'(m_full));
    check("sent_cnt", 32'(sent_cnt), 32'(m_cnt % 256));
    if ((out_valid & forbid) != 0) saw_bad = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid[i] && out_ready[i]) begin
        log_sink.push_back(i);
        log_data.push_back(out_data);
      end
    end
    if (rst_n) begin
      m_drain = m_full && out_ready[m_sink];
      if (m_drain) m_cnt++;
      if (in_valid && exp_rdy) begin
        g      = pick(en_mask, m_ptr);
        m_data = in_data;
        m_sink = g;
        m_ptr  = (g + 1) % 4;
        m_full = 1'b1;
      end else if (m_drain) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a beat and hold it until the handshake completes; leaves in_valid high.
  task automatic drive_beat(input logic [7:0] d, output int waits);
    logic rdy;
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    rdy      = 1'b0;
    while (!rdy) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      waits++;
      if (!rdy && waits > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: beat 0x%0h not accepted after %0d cycles", d, waits);
        return;
      end
    end
  endtask

  task automatic clear_log();
    log_sink.delete();
    log_data.delete();
  endtask

  int w;
  int total;

  initial begin
    step(2);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    rst_n     = 1'b1;
    en_mask   = 4'hF;
    out_ready = 4'hF;

    // Back-to-back beats over all four sinks.
    clear_log();
    total = 0;
    for (int i = 0; i < 8; i++) begin
      drive_beat(8'h10 + 8'(i), w);
      total += w;
    end
    in_valid = 1'b0;
    step(2);
    check("b2b_cycles", 32'(total), 32'd8);
    check("b2b_count", 32'(log_sink.size()), 32'd8);
    for (int k = 0; k < 8 && k < log_sink.size(); k++) begin
      check("b2b_sink", 32'(log_sink[k]), 32'(k % 4));
      check("b2b_data", 32'(log_data[k]), 32'h10 + 32'(k));
    end
    check("b2b_sent_cnt", 32'(sent_cnt), 32'd8);

    // Only odd sinks enabled.
    clear_log();
    en_mask = 4'b1010;
    forbid  = 4'b0101;
    saw_bad = 1'b0;
    for (int i = 0; i < 4; i++) drive_beat(8'h20 + 8'(i), w);
    in_valid = 1'b0;
    step(2);
    check("mask_count", 32'(log_sink.size()), 32'd4);
    for (int k = 0; k < 4 && k < log_sink.size(); k++)
      check("mask_sink", 32'(log_sink[k]), (k % 2 == 0) ? 32'd1 : 32'd3);
    check("mask_forbidden_valid", 32'(saw_bad), 32'd0);
    forbid = '0;
    check("mask_sent_cnt", 32'(sent_cnt), 32'd12);

    // Back-pressure on sink 0, then release with a pending beat.
    clear_log();
    en_mask   = 4'hF;
    out_ready = 4'b1110;
    drive_beat(8'hAA, w);
    in_data = 8'hBB;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'b0001);
      check("hold_data", 32'(out_data), 32'hAA);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 4'hF;
    drive_beat(8'hBB, w);
    in_valid = 1'b0;
    check("release_same_cycle", 32'(w), 32'd1);
    check("release_next_valid", 32'(out_valid), 32'b0010);
    check("release_next_data", 32'(out_data), 32'hBB);
    check("release_sink", (log_sink.size() > 0) ? 32'(log_sink[0]) : 32'hFFFF, 32'd0);
    check("release_cnt", 32'(sent_cnt), 32'd13);
    step(2);

    // Empty mask blocks everything until a sink is enabled.
    clear_log();
    en_mask  = 4'b0000;
    in_valid = 1'b1;
    in_data  = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nomask_in_ready", 32'(in_ready), 32'd0);
      check("nomask_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
    end
    en_mask = 4'b0100;
    drive_beat(8'hCC, w);
    in_valid = 1'b0;
    step(2);
    check("nomask_sink", (log_sink.size() == 1) ? 32'(log_sink[0]) : 32'hFFFF, 32'd2);

    // Held beat survives its sink being disabled; later grants avoid that sink.
    clear_log();
    en_mask   = 4'hF;
    out_ready = 4'h0;
    drive_beat(8'h55, w);
    in_valid = 1'b0;
    en_mask  = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("masked_hold_valid", 32'(out_valid), 32'b1000);
      @(posedge clk);
      #1;
    end
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) drive_beat(8'h60 + 8'(i), w);
    in_valid = 1'b0;
    step(2);
    check("masked_count", 32'(log_sink.size()), 32'd5);
    if (log_sink.size() == 5) begin
      check("masked_sink", 32'(log_sink[0]), 32'd3);
      check("masked_data", 32'(log_data[0]), 32'h55);
      check("skip_sink0", 32'(log_sink[1]), 32'd0);
      check("skip_sink1", 32'(log_sink[2]), 32'd1);
      check("skip_sink2", 32'(log_sink[3]), 32'd2);
      check("skip_sink3", 32'(log_sink[4]), 32'd0);
    end

    // Asynchronous reset while a beat is held.
    out_ready = 4'h0;
    drive_beat(8'h77, w);
    in_valid = 1'b0;
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_sent_cnt", 32'(sent_cnt), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd0);
    check("async_out_data", 32'(out_data), 32'd0);
    step(1);
    rst_n     = 1'b1;
    out_ready = 4'hF;
    clear_log();
    drive_beat(8'h88, w);
    in_valid = 1'b0;
    step(2);
    check("post_reset_sink", (log_sink.size() == 1) ? 32'(log_sink[0]) : 32'hFFFF, 32'd0);
    check("post_reset_cnt", 32'(sent_cnt), 32'd1);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) en_mask = 4'($urandom);
      out_ready = 4'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      step(1);
    end
    in_valid = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_dispatch_1x4.md
# stream_dispatch_1x4

Registered 1-to-4 stream dispatcher that drives the team's 1-to-4 demux datapath. It accepts beats from a single valid/ready source and routes each one to exactly one of four sinks. The sink is chosen round-robin among the outputs currently enabled by a mask, and each beat is held until that sink accepts it. The block sits between a single producer and four parallel consumers (e.g. worker lanes) and replaces the bare select lines of the combinational demux with sequenced, back-pressured routing.

## Interface
- DATA_W, 8, beat width
- CNT_W, 8, width of delivered-beat counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en_mask  in  4  per-sink enable; bit i = sink i eligible
- in_valid  in  1  source beat valid
- in_ready  out  1  block accepts beat this cycle
- in_data  in  DATA_W  source beat
- out_valid  out  4  one-hot; bit i = beat presented to sink i
- out_ready  in  4  per-sink ready
- out_data  out  DATA_W  beat payload, shared by all sinks
- sel  out  2  index of sink currently holding the beat
- busy  out  1  holding register occupied
- sent_cnt  out  CNT_W  beats delivered since reset, wraps

## Operation
- States: EMPTY, FULL. Reset → EMPTY.
- Pointer ptr[1:0] marks the next candidate sink. Reset value is 0.
- Grant g: the first index with en_mask set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). The grant is valid only if en_mask != 0.
- Drain: a drain occurs when state = FULL and out_ready[sel] = 1.
- Ready: in_ready = (en_mask != 0) && (state = EMPTY || drain).
- Accept: an accept occurs when in_valid && in_ready. On accept:
  - data_q ← in_data
  - sel ← g
  - ptr ← g+1 mod 4
  - state ← FULL
- Drain without accept: state ← EMPTY.
- Drain and accept in the same cycle: the new beat is loaded and state stays FULL. This gives back-to-back throughput of 1 beat/cycle.
- Outputs:
  - out_valid = (state = FULL) ? onehot(sel) : 0
  - out_data = data_q
  - busy = (state = FULL)
- sent_cnt increments by 1 on each drain and wraps modulo 2^CNT_W.
- en_mask changes:
  - They affect only future grants.
  - A held beat stays on its sink even if that sink's bit is cleared.
  - With en_mask = 0, nothing is accepted and a held beat still drains.
- Sinks that are not selected never see out_valid; their out_ready is ignored.
- Reset mid-transfer drops the held beat. There is no recovery.

## Timing
- Reset values: in_ready=0 while rst_n low, out_valid=0, out_data=0, sel=0, busy=0, sent_cnt=0, ptr=0.
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N (visible in cycle N+1).
- in_ready is combinational from en_mask, state, sel and out_ready. There is no path from in_valid to in_ready.
- All state updates happen on the rising clk edge. Reset is asynchronous assert and synchronous deassert, handled at the system level.

## Structure
- Package stream_dispatch_pkg holds:
  - NUM_OUT = 4
  - SEL_W = 2
  - state enum {EMPTY, FULL}
- Sub-module rr_pick4 is purely combinational:
  - inputs: mask[3:0], ptr[1:0]
  - outputs: grant[1:0], any
- The top level holds the FSM, data register, pointer and counter.

## Test plan
- Reset, all sinks ready, en_mask=4'hF, 8 back-to-back beats 0x10..0x17 → sinks 0,1,2,3,0,1,2,3; one beat per cycle after first; sent_cnt=8.
- en_mask=4'b1010, 4 beats → sinks 1,3,1,3; out_valid bits 0 and 2 never asserted.
- Beat 0xAA to sink 0, out_ready[0]=0 for 5 cycles → out_valid=4'b0001 and data held stable; in_ready=0; release → drained and next beat accepted same cycle.
- en_mask=0 with in_valid=1 → in_ready=0 and nothing accepted; set en_mask=4'b0100 → next beat goes to sink 2.
- Clear en_mask bit of sink holding beat 0x55 → beat still delivered to that sink; next grant skips it.
- Assert rst_n=0 while FULL → out_valid=0, busy=0, sent_cnt=0 immediately (asynchronous); first post-reset beat goes to sink 0.
